// File: rtl/sync_pkg.sv
// Shared constants and helpers for the filtered multi-channel bus synchroniser.
package sync_pkg;

  localparam int OVW_HOLD   = 0;
  localparam int OVW_LATEST = 1;

  function automatic int cnt_width(input int stable_cycles);
    return (stable_cycles < 1) ? 1 : $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/sync_bus_chan.sv
// One channel: N_STAGE synchroniser, stability filter, commit logic and
// valid/ready output register with sticky overflow.
module sync_bus_chan
  import sync_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter int               N_STAGE       = 2,
  parameter int               STABLE_CYCLES = 4,
  parameter logic [WIDTH-1:0] RST_VAL       = '0,
  parameter int               OVERWRITE     = OVW_LATEST
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam int            CW      = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_ff [N_STAGE];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] sync_d;
  logic [WIDTH-1:0] committed;
  logic [CW-1:0]    cnt;
  logic             want, stall, blocked, commit, ovf_set;

  assign sync = sync_ff[N_STAGE-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_STAGE; i++) sync_ff[i] <= RST_VAL;
    end else begin
      sync_ff[0] <= din;
      for (int i = 1; i < N_STAGE; i++) sync_ff[i] <= sync_ff[i-1];
    end
  end

  // Stability filter: counter restarts whenever the synced value moves
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_d <= RST_VAL;
      cnt    <= '0;
    end else begin
      sync_d <= sync;
      if (sync != sync_d)    cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end
  end

  // A held output under HOLD mode defers the commit; committed stays old so it retries
  always_comb begin
    want    = (sync == sync_d) && (cnt == CNT_MAX) && (sync != committed);
    stall   = dout_vld && !dout_rdy;
    blocked = (OVERWRITE == OVW_HOLD) && stall;
    commit  = want && !blocked;
    ovf_set = want && stall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      committed <= RST_VAL;
      dout      <= RST_VAL;
      dout_vld  <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (commit) begin
        committed <= sync;
        dout      <= sync;
        dout_vld  <= 1'b1;
      end else if (dout_vld && dout_rdy) begin
        dout_vld  <= 1'b0;
      end
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/sync_bus_filtered.sv
// CHANNELS independent filtered bus synchronisers; top level only slices and packs.
module sync_bus_filtered
  import sync_pkg::*;
#(
  parameter int               CHANNELS      = 2,
  parameter int               WIDTH         = 8,
  parameter int               N_STAGE       = 2,
  parameter int               STABLE_CYCLES = 4,
  parameter logic [WIDTH-1:0] RST_VAL       = '0,
  parameter int               OVERWRITE     = OVW_LATEST
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] din,
  output logic [CHANNELS*WIDTH-1:0] dout,
  output logic [CHANNELS-1:0]       dout_vld,
  input  logic [CHANNELS-1:0]       dout_rdy,
  output logic [CHANNELS-1:0]       ovf,
  input  logic [CHANNELS-1:0]       ovf_clr
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    sync_bus_chan #(
      .WIDTH        (WIDTH),
      .N_STAGE      (N_STAGE),
      .STABLE_CYCLES(STABLE_CYCLES),
      .RST_VAL      (RST_VAL),
      .OVERWRITE    (OVERWRITE)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .din     (din[c*WIDTH +: WIDTH]),
      .dout    (dout[c*WIDTH +: WIDTH]),
      .dout_vld(dout_vld[c]),
      .dout_rdy(dout_rdy[c]),
      .ovf     (ovf[c]),
      .ovf_clr (ovf_clr[c])
    );
  end

endmodule

// File: tb/tb_sync_bus_filtered.sv
// Directed bench for sync_bus_filtered: one latest-wins instance, one hold-mode instance.
module tb_sync_bus_filtered;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] din, din_h;
  logic [15:0] dout, dout_h;
  logic [1:0]  vld, vld_h, rdy, rdy_h, ovf, ovf_h, clr, clr_h;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  sync_bus_filtered dut (
    .clk(clk), .rst_n(rst_n), .din(din), .dout(dout), .dout_vld(vld),
    .dout_rdy(rdy), .ovf(ovf), .ovf_clr(clr)
  );

  sync_bus_filtered #(.OVERWRITE(0)) dut_h (
    .clk(clk), .rst_n(rst_n), .din(din_h), .dout(dout_h), .dout_vld(vld_h),
    .dout_rdy(rdy_h), .ovf(ovf_h), .ovf_clr(clr_h)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; din = '0; din_h = '0;
    rdy = 2'b11; rdy_h = 2'b11; clr = '0; clr_h = '0;

    // Reset state
    tick(5);
    chk("rst_dout", dout, 0);   chk("rst_vld", vld, 0);   chk("rst_ovf", ovf, 0);
    chk("rst_dout_h", dout_h, 0); chk("rst_vld_h", vld_h, 0); chk("rst_ovf_h", ovf_h, 0);
    rst_n = 1'b1;
    tick(3);

    // Basic commit: valid on the 8th edge after the change, one cycle only
    din[7:0] = 8'hA5;
    tick(7);  chk("lat_early_vld", vld, 2'b00);
    tick(1);  chk("lat_vld", vld, 2'b01); chk("lat_dout", dout[7:0], 8'hA5);
    tick(1);  chk("lat_vld_drop", vld, 2'b00); chk("ch1_dout", dout[15:8], 8'h00);

    // Glitch of 3 cycles is rejected
    din[7:0] = 8'h3C; tick(3); din[7:0] = 8'hA5;
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 12; i++) begin tick(1); seen |= vld[0]; end
      chk("glitch_novld", seen, 1'b0);
    end
    chk("glitch_dout", dout[7:0], 8'hA5);
    // Held level commits
    din[7:0] = 8'h3C;
    tick(7);  chk("level_early", vld[0], 1'b0);
    tick(1);  chk("level_vld", vld[0], 1'b1); chk("level_dout", dout[7:0], 8'h3C);
    tick(1);  chk("level_drop", vld[0], 1'b0);

    // Backpressure, latest-wins
    rdy[0] = 1'b0;
    din[7:0] = 8'h11; tick(8);
    chk("bp_vld1", vld[0], 1'b1); chk("bp_dout1", dout[7:0], 8'h11); chk("bp_noovf", ovf[0], 1'b0);
    din[7:0] = 8'h22; tick(8);
    chk("bp_dout2", dout[7:0], 8'h22); chk("bp_vld2", vld[0], 1'b1); chk("bp_ovf", ovf[0], 1'b1);
    rdy[0] = 1'b1; tick(1);
    chk("bp_xfer", vld[0], 1'b0); chk("bp_ovf_sticky", ovf[0], 1'b1);
    clr[0] = 1'b1; tick(1); clr[0] = 1'b0;
    chk("ovf_clr", ovf[0], 1'b0);
    rdy[0] = 1'b0;
    din[7:0] = 8'h33; tick(8); chk("clr_race_vld", vld[0], 1'b1);
    din[7:0] = 8'h44; tick(7);
    clr[0] = 1'b1; tick(1); clr[0] = 1'b0;
    chk("set_wins", ovf[0], 1'b1); chk("set_wins_dout", dout[7:0], 8'h44);
    rdy[0] = 1'b1; tick(1);
    clr[0] = 1'b1; tick(1); clr[0] = 1'b0;
    chk("clr2", ovf[0], 1'b0);

    // Transfer and commit on the same edge
    rdy[0] = 1'b0;
    din[7:0] = 8'h55; tick(8); chk("sim_vld1", vld[0], 1'b1);
    din[7:0] = 8'h66; tick(7);
    rdy[0] = 1'b1; tick(1);
    chk("sim_dout", dout[7:0], 8'h66); chk("sim_vld", vld[0], 1'b1); chk("sim_noovf", ovf[0], 1'b0);
    tick(1); chk("sim_drop", vld[0], 1'b0);

    // Backpressure, hold mode
    rdy_h[0] = 1'b0;
    din_h[7:0] = 8'h11; tick(8);
    chk("hold_vld1", vld_h[0], 1'b1); chk("hold_dout1", dout_h[7:0], 8'h11);
    din_h[7:0] = 8'h22; tick(8);
    chk("hold_keep", dout_h[7:0], 8'h11); chk("hold_ovf", ovf_h[0], 1'b1);
    rdy_h[0] = 1'b1; tick(1); rdy_h[0] = 1'b0;
    chk("hold_next_dout", dout_h[7:0], 8'h22); chk("hold_next_vld", vld_h[0], 1'b1);
    tick(1);
    chk("hold_held_dout", dout_h[7:0], 8'h22); chk("hold_held_vld", vld_h[0], 1'b1);
    rdy_h[0] = 1'b1; tick(1); chk("hold_xfer2", vld_h[0], 1'b0);
    chk("ch1_vld_h", vld_h[1], 1'b0);

    // Asynchronous reset between edges while valid
    rdy[0] = 1'b0;
    din[7:0] = 8'h77; tick(8); chk("ar_pre_vld", vld[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_dout", dout, 0); chk("ar_vld", vld, 0); chk("ar_ovf", ovf, 0);
    din[7:0] = 8'hA5; rdy[0] = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(7); chk("ar_early", vld[0], 1'b0);
    tick(1); chk("ar_vld_re", vld[0], 1'b1); chk("ar_dout_re", dout[7:0], 8'hA5);
    chk("ar_ch1", vld[1], 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
